// File: rtl/traffic_stat_collector.sv
// Per-class receive/send statistics with a record-by-record dump over a valid/ready port.
// Stats update 1 cycle after update/sent_done; a record is held stable while rec_valid && !rec_ready.
// Optional STAT_MINMAX_EN builds per-class min/max head-to-head latency tracking.
module traffic_stat_collector #(
  parameter int C            = 4,
  parameter int MAX_SIM_CLKs = 100000,
  parameter int MAX_PCK_NUM  = 10000,
  parameter int DSTw         = 5,
  localparam int Cw          = (C > 1) ? $clog2(C) : 1,
  localparam int CLK_CNTw    = $clog2(MAX_SIM_CLKs + 1),
  localparam int PCK_CNTw    = $clog2(MAX_PCK_NUM + 1),
  parameter int SUMw         = CLK_CNTw + PCK_CNTw,
  localparam int DISTw       = DSTw + PCK_CNTw
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                update,
  input  logic [Cw-1:0]       pck_class,
  input  logic [CLK_CNTw-1:0] time_stamp_h2h,
  input  logic [CLK_CNTw-1:0] time_stamp_h2t,
  input  logic [DSTw-1:0]     distance,
  input  logic                sent_done,
  input  logic [Cw-1:0]       sent_class,
  input  logic                clear,
  input  logic                report_req,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [Cw-1:0]       rec_class,
  output logic [PCK_CNTw-1:0] rec_rcv_cnt,
  output logic [PCK_CNTw-1:0] rec_sent_cnt,
  output logic [SUMw-1:0]     rec_sum_h2h,
  output logic [SUMw-1:0]     rec_sum_h2t,
  output logic [DISTw-1:0]    rec_sum_dist,
  output logic [CLK_CNTw-1:0] rec_min_h2h,
  output logic [CLK_CNTw-1:0] rec_max_h2h,
  output logic                dump_busy,
  output logic                dump_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [Cw:0]         LP_C    = C[Cw:0];
  localparam logic [Cw-1:0]       LP_LAST = Cw'(C - 1);
  localparam logic [PCK_CNTw-1:0] LP_ONE  = PCK_CNTw'(1);

  function automatic logic [PCK_CNTw-1:0] f_inc_cnt(input logic [PCK_CNTw-1:0] v);
    return (&v) ? v : v + LP_ONE;
  endfunction

  function automatic logic [SUMw-1:0] f_sat_sum(input logic [SUMw-1:0] acc,
                                                input logic [SUMw-1:0] add);
    logic [SUMw:0] s;
    s = {1'b0, acc} + {1'b0, add};
    return s[SUMw] ? '1 : s[SUMw-1:0];
  endfunction

  function automatic logic [DISTw-1:0] f_sat_dist(input logic [DISTw-1:0] acc,
                                                  input logic [DISTw-1:0] add);
    logic [DISTw:0] s;
    s = {1'b0, acc} + {1'b0, add};
    return s[DISTw] ? '1 : s[DISTw-1:0];
  endfunction

  logic [PCK_CNTw-1:0] r_rcv_cnt  [C];
  logic [PCK_CNTw-1:0] r_sent_cnt [C];
  logic [SUMw-1:0]     r_sum_h2h  [C];
  logic [SUMw-1:0]     r_sum_h2t  [C];
  logic [DISTw-1:0]    r_sum_dist [C];

  logic w_upd_ok;
  logic w_snd_ok;

  // Out-of-range class indices (possible when C is not a power of two) are dropped.
  assign w_upd_ok = update    && ({1'b0, pck_class}  < LP_C);
  assign w_snd_ok = sent_done && ({1'b0, sent_class} < LP_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C; i++) begin
        r_rcv_cnt[i]  <= '0;
        r_sent_cnt[i] <= '0;
        r_sum_h2h[i]  <= '0;
        r_sum_h2t[i]  <= '0;
        r_sum_dist[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < C; i++) begin
        r_rcv_cnt[i]  <= '0;
        r_sent_cnt[i] <= '0;
        r_sum_h2h[i]  <= '0;
        r_sum_h2t[i]  <= '0;
        r_sum_dist[i] <= '0;
      end
    end else begin
      if (w_upd_ok) begin
        r_rcv_cnt[pck_class]  <= f_inc_cnt(r_rcv_cnt[pck_class]);
        r_sum_h2h[pck_class]  <= f_sat_sum(r_sum_h2h[pck_class], SUMw'(time_stamp_h2h));
        r_sum_h2t[pck_class]  <= f_sat_sum(r_sum_h2t[pck_class], SUMw'(time_stamp_h2t));
        r_sum_dist[pck_class] <= f_sat_dist(r_sum_dist[pck_class], DISTw'(distance));
      end
      if (w_snd_ok) begin
        r_sent_cnt[sent_class] <= f_inc_cnt(r_sent_cnt[sent_class]);
      end
    end
  end

`ifdef STAT_MINMAX_EN
  logic [CLK_CNTw-1:0] r_min_h2h [C];
  logic [CLK_CNTw-1:0] r_max_h2h [C];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < C; i++) begin
        r_min_h2h[i] <= '1;
        r_max_h2h[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < C; i++) begin
        r_min_h2h[i] <= '1;
        r_max_h2h[i] <= '0;
      end
    end else if (w_upd_ok) begin
      if (time_stamp_h2h < r_min_h2h[pck_class]) r_min_h2h[pck_class] <= time_stamp_h2h;
      if (time_stamp_h2h > r_max_h2h[pck_class]) r_max_h2h[pck_class] <= time_stamp_h2h;
    end
  end
`endif

  logic [1:0]          r_state;
  logic [Cw-1:0]       r_index;
  logic [Cw-1:0]       r_rec_class;
  logic [PCK_CNTw-1:0] r_rec_rcv_cnt;
  logic [PCK_CNTw-1:0] r_rec_sent_cnt;
  logic [SUMw-1:0]     r_rec_sum_h2h;
  logic [SUMw-1:0]     r_rec_sum_h2t;
  logic [DISTw-1:0]    r_rec_sum_dist;
  logic [CLK_CNTw-1:0] r_rec_min_h2h;
  logic [CLK_CNTw-1:0] r_rec_max_h2h;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (report_req) begin
            r_state <= S_LOAD;
            r_index <= '0;
          end
        end
        S_LOAD: r_state <= S_SEND;
        S_SEND: begin
          if (rec_ready) begin
            if (r_index == LP_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_index <= r_index + Cw'(1);
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Snapshot of live stats; an update landing on the same edge is not included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rec_class    <= '0;
      r_rec_rcv_cnt  <= '0;
      r_rec_sent_cnt <= '0;
      r_rec_sum_h2h  <= '0;
      r_rec_sum_h2t  <= '0;
      r_rec_sum_dist <= '0;
      r_rec_min_h2h  <= '0;
      r_rec_max_h2h  <= '0;
    end else if (clear) begin
      r_rec_class    <= '0;
      r_rec_rcv_cnt  <= '0;
      r_rec_sent_cnt <= '0;
      r_rec_sum_h2h  <= '0;
      r_rec_sum_h2t  <= '0;
      r_rec_sum_dist <= '0;
      r_rec_min_h2h  <= '0;
      r_rec_max_h2h  <= '0;
    end else if (r_state == S_LOAD) begin
      r_rec_class    <= r_index;
      r_rec_rcv_cnt  <= r_rcv_cnt[r_index];
      r_rec_sent_cnt <= r_sent_cnt[r_index];
      r_rec_sum_h2h  <= r_sum_h2h[r_index];
      r_rec_sum_h2t  <= r_sum_h2t[r_index];
      r_rec_sum_dist <= r_sum_dist[r_index];
`ifdef STAT_MINMAX_EN
      r_rec_min_h2h  <= r_min_h2h[r_index];
      r_rec_max_h2h  <= r_max_h2h[r_index];
`else
      r_rec_min_h2h  <= '0;
      r_rec_max_h2h  <= '0;
`endif
    end
  end

  assign rec_valid    = (r_state == S_SEND);
  assign dump_busy    = (r_state != S_IDLE);
  assign dump_done    = (r_state == S_DONE);
  assign rec_class    = r_rec_class;
  assign rec_rcv_cnt  = r_rec_rcv_cnt;
  assign rec_sent_cnt = r_rec_sent_cnt;
  assign rec_sum_h2h  = r_rec_sum_h2h;
  assign rec_sum_h2t  = r_rec_sum_h2t;
  assign rec_sum_dist = r_rec_sum_dist;
  assign rec_min_h2h  = r_rec_min_h2h;
  assign rec_max_h2h  = r_rec_max_h2h;

endmodule

// File: tb/tb_traffic_stat_collector.sv
// Directed bench for traffic_stat_collector: a default instance plus a small-counter
// instance (MAX_PCK_NUM=3) sharing the same stimulus for saturation checks.
module tb_traffic_stat_collector;

  localparam int C        = 4;
  localparam int Cw       = 2;
  localparam int CLK_CNTw = 17;
  localparam int PCK_CNTw = 14;
  localparam int SUMw     = 31;
  localparam int DISTw    = 19;
  localparam int S_PCKw   = 2;
  localparam int S_SUMw   = 19;
  localparam int S_DISTw  = 7;

`ifdef STAT_MINMAX_EN
  localparam logic [CLK_CNTw-1:0] EXP_MIN_EMPTY = '1;
  localparam bit MINMAX = 1'b1;
`else
  localparam logic [CLK_CNTw-1:0] EXP_MIN_EMPTY = '0;
  localparam bit MINMAX = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                update;
  logic [Cw-1:0]       pck_class;
  logic [CLK_CNTw-1:0] time_stamp_h2h;
  logic [CLK_CNTw-1:0] time_stamp_h2t;
  logic [4:0]          distance;
  logic                sent_done;
  logic [Cw-1:0]       sent_class;
  logic                clear;
  logic                report_req;
  logic                rec_ready;

  logic                rec_valid, dump_busy, dump_done;
  logic [Cw-1:0]       rec_class;
  logic [PCK_CNTw-1:0] rec_rcv_cnt, rec_sent_cnt;
  logic [SUMw-1:0]     rec_sum_h2h, rec_sum_h2t;
  logic [DISTw-1:0]    rec_sum_dist;
  logic [CLK_CNTw-1:0] rec_min_h2h, rec_max_h2h;

  logic                s_rec_valid, s_dump_busy, s_dump_done;
  logic [Cw-1:0]       s_rec_class;
  logic [S_PCKw-1:0]   s_rec_rcv_cnt, s_rec_sent_cnt;
  logic [S_SUMw-1:0]   s_rec_sum_h2h, s_rec_sum_h2t;
  logic [S_DISTw-1:0]  s_rec_sum_dist;
  logic [CLK_CNTw-1:0] s_rec_min_h2h, s_rec_max_h2h;

  always #5 clk = ~clk;

  traffic_stat_collector u_dut (
    .clk(clk), .reset(reset), .update(update), .pck_class(pck_class),
    .time_stamp_h2h(time_stamp_h2h), .time_stamp_h2t(time_stamp_h2t),
    .distance(distance), .sent_done(sent_done), .sent_class(sent_class),
    .clear(clear), .report_req(report_req), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_class(rec_class), .rec_rcv_cnt(rec_rcv_cnt),
    .rec_sent_cnt(rec_sent_cnt), .rec_sum_h2h(rec_sum_h2h),
    .rec_sum_h2t(rec_sum_h2t), .rec_sum_dist(rec_sum_dist),
    .rec_min_h2h(rec_min_h2h), .rec_max_h2h(rec_max_h2h),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  traffic_stat_collector #(.MAX_PCK_NUM(3)) u_sat (
    .clk(clk), .reset(reset), .update(update), .pck_class(pck_class),
    .time_stamp_h2h(time_stamp_h2h), .time_stamp_h2t(time_stamp_h2t),
    .distance(distance), .sent_done(sent_done), .sent_class(sent_class),
    .clear(clear), .report_req(report_req), .rec_valid(s_rec_valid),
    .rec_ready(rec_ready), .rec_class(s_rec_class), .rec_rcv_cnt(s_rec_rcv_cnt),
    .rec_sent_cnt(s_rec_sent_cnt), .rec_sum_h2h(s_rec_sum_h2h),
    .rec_sum_h2t(s_rec_sum_h2t), .rec_sum_dist(s_rec_sum_dist),
    .rec_min_h2h(s_rec_min_h2h), .rec_max_h2h(s_rec_max_h2h),
    .dump_busy(s_dump_busy), .dump_done(s_dump_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [Cw-1:0]       cap_cls   [C];
  logic [PCK_CNTw-1:0] cap_rcv   [C];
  logic [PCK_CNTw-1:0] cap_sent  [C];
  logic [SUMw-1:0]     cap_h2h   [C];
  logic [SUMw-1:0]     cap_h2t   [C];
  logic [DISTw-1:0]    cap_dist  [C];
  logic [CLK_CNTw-1:0] cap_min   [C];
  logic [CLK_CNTw-1:0] cap_max   [C];
  logic [S_PCKw-1:0]   cap_srcv  [C];
  logic [S_PCKw-1:0]   cap_ssent [C];
  logic [S_DISTw-1:0]  cap_sdist [C];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; leaves the bench on the next falling edge.
  task automatic pkt(input logic [Cw-1:0] cls, input logic [CLK_CNTw-1:0] h2h,
                     input logic [CLK_CNTw-1:0] h2t, input logic [4:0] dst,
                     input logic snd);
    update         = 1'b1;
    pck_class      = cls;
    time_stamp_h2h = h2h;
    time_stamp_h2t = h2t;
    distance       = dst;
    sent_done      = snd;
    sent_class     = cls;
    @(negedge clk);
    update    = 1'b0;
    sent_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Full dump with rec_ready high; captures records from both instances.
  task automatic do_dump(input string tag);
    int busy_cyc;
    int done_cyc;
    int idx;
    busy_cyc = 0;
    done_cyc = 0;
    idx      = 0;
    rec_ready  = 1'b1;
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    while (dump_busy && busy_cyc < 50) begin
      busy_cyc++;
      if (dump_done) done_cyc = busy_cyc;
      if (rec_valid && idx < C) begin
        cap_cls[idx]   = rec_class;
        cap_rcv[idx]   = rec_rcv_cnt;
        cap_sent[idx]  = rec_sent_cnt;
        cap_h2h[idx]   = rec_sum_h2h;
        cap_h2t[idx]   = rec_sum_h2t;
        cap_dist[idx]  = rec_sum_dist;
        cap_min[idx]   = rec_min_h2h;
        cap_max[idx]   = rec_max_h2h;
        cap_srcv[idx]  = s_rec_rcv_cnt;
        cap_ssent[idx] = s_rec_sent_cnt;
        cap_sdist[idx] = s_rec_sum_dist;
      end
      if (rec_valid) idx++;
      @(negedge clk);
    end
    chk({tag, "_len"},     busy_cyc, 2 * C + 1);
    chk({tag, "_donepos"}, done_cyc, 2 * C + 1);
    chk({tag, "_nrec"},    idx, C);
  endtask

  initial begin
    int k;
    reset = 1'b1; update = 1'b0; pck_class = '0; time_stamp_h2h = '0;
    time_stamp_h2t = '0; distance = '0; sent_done = 1'b0; sent_class = '0;
    clear = 1'b0; report_req = 1'b0; rec_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", rec_valid, 0);
    chk("rst_busy",  dump_busy, 0);
    chk("rst_done",  dump_done, 0);
    chk("rst_rcv",   rec_rcv_cnt, 0);
    chk("rst_min",   rec_min_h2h, 0);
    reset = 1'b0;
    @(negedge clk);

    // Empty dump
    do_dump("empty");
    for (int i = 0; i < C; i++) begin
      chk("empty_cls",  cap_cls[i], i);
      chk("empty_rcv",  cap_rcv[i], 0);
      chk("empty_sent", cap_sent[i], 0);
      chk("empty_h2h",  cap_h2h[i], 0);
      chk("empty_dist", cap_dist[i], 0);
      chk("empty_min",  cap_min[i], EXP_MIN_EMPTY);
      chk("empty_max",  cap_max[i], 0);
    end

    // Three packets on class 1
    pkt(2'd1, 17'd10, 17'd14, 5'd2, 1'b0);
    pkt(2'd1, 17'd25, 17'd30, 5'd3, 1'b0);
    pkt(2'd1, 17'd7,  17'd9,  5'd1, 1'b0);
    do_dump("c1");
    chk("c1_rcv",  cap_rcv[1], 3);
    chk("c1_sent", cap_sent[1], 0);
    chk("c1_h2h",  cap_h2h[1], 42);
    chk("c1_h2t",  cap_h2t[1], 53);
    chk("c1_dist", cap_dist[1], 6);
    chk("c1_min",  cap_min[1], MINMAX ? 7 : 0);
    chk("c1_max",  cap_max[1], MINMAX ? 25 : 0);
    chk("c1_rcv0", cap_rcv[0], 0);
    chk("c1_rcv2", cap_rcv[2], 0);

    // Clear, then update and sent_done together on class 0
    pulse_clear();
    for (int i = 0; i < 5; i++) pkt(2'd0, 17'd3, 17'd4, 5'd1, 1'b1);
    do_dump("both");
    chk("both_rcv",  cap_rcv[0], 5);
    chk("both_sent", cap_sent[0], 5);
    chk("both_h2h",  cap_h2h[0], 15);
    chk("both_c1",   cap_rcv[1], 0);

    // Stalled record 0 while class 0 keeps receiving
    rec_ready  = 1'b0;
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", rec_valid, 1);
      chk("stall_cls",   rec_class, 0);
      chk("stall_rcv",   rec_rcv_cnt, 5);
      update = 1'b1; pck_class = 2'd0; time_stamp_h2h = 17'd2;
      @(negedge clk);
    end
    update = 1'b0;
    chk("stall_rcv_end", rec_rcv_cnt, 5);
    rec_ready = 1'b1;
    k = 0;
    while (dump_busy && k < 40) begin
      k++;
      @(negedge clk);
    end
    chk("stall_exit", dump_busy, 0);
    do_dump("after");
    chk("after_rcv", cap_rcv[0], 9);

    // Saturation: small instance pins at 3, dist sum pins at 127
    pulse_clear();
    for (int i = 0; i < 5; i++) pkt(2'd2, 17'd0, 17'd0, 5'd31, 1'b1);
    do_dump("sat");
    chk("sat_rcv",   cap_srcv[2], 3);
    chk("sat_sent",  cap_ssent[2], 3);
    chk("sat_dist",  cap_sdist[2], 127);
    chk("wide_rcv",  cap_rcv[2], 5);
    chk("wide_dist", cap_dist[2], 155);

    // Clear during SEND of class 1
    rec_ready  = 1'b1;
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    k = 0;
    while (!(rec_valid && rec_class == 2'd1) && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("clr_reach_c1", rec_class, 1);
    rec_ready = 1'b0;
    clear     = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_valid", rec_valid, 0);
    chk("clr_busy",  dump_busy, 0);
    rec_ready = 1'b1;
    do_dump("clr");
    chk("clr_rcv2",  cap_rcv[2], 0);
    chk("clr_dist2", cap_dist[2], 0);

    // Asynchronous reset mid-dump
    pkt(2'd3, 17'd5, 17'd6, 5'd2, 1'b0);
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_pre_busy", dump_busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", rec_valid, 0);
    chk("arst_busy",  dump_busy, 0);
    chk("arst_class", rec_class, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_dump("arst");
    chk("arst_rcv3", cap_rcv[3], 0);
    chk("arst_h2h3", cap_h2h[3], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_stat_collector.md
# traffic_stat_collector

Per-endpoint statistics collector sitting directly downstream of the traffic generator. Consumes its `update` pulse and packet metadata (`time_stamp_h2h`, `time_stamp_h2t`, `distance`, `pck_class_out`, `sent_done`). Keeps per-class counters and latency accumulators. On request, serialises one record per class over a valid/ready port to the simulation analyser.

## Interface
Parameters:
- `C`, 4: number of message classes; `Cw = (C>1)? log2(C):1`.
- `MAX_SIM_CLKs`, 100000: sets `CLK_CNTw = log2(MAX_SIM_CLKs+1)`.
- `MAX_PCK_NUM`, 10000: sets `PCK_CNTw = log2(MAX_PCK_NUM+1)`.
- `DSTw`, 5: width of `distance`.
- `SUMw`, `CLK_CNTw+PCK_CNTw`: latency accumulator width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `update`, in, 1: one-cycle pulse; packet received, metadata valid this cycle.
- `pck_class`, in, Cw: class of received packet.
- `time_stamp_h2h`, in, CLK_CNTw: head-to-head latency.
- `time_stamp_h2t`, in, CLK_CNTw: head-to-tail latency.
- `distance`, in, DSTw: hop count.
- `sent_done`, in, 1: one-cycle pulse; a packet was sent (tail flit).
- `sent_class`, in, Cw: class of sent packet.
- `clear`, in, 1: synchronous clear of all statistics.
- `report_req`, in, 1: pulse; starts a dump.
- `rec_valid`, out, 1: record valid.
- `rec_ready`, in, 1: consumer accepts record.
- `rec_class`, out, Cw; `rec_rcv_cnt`, out, PCK_CNTw; `rec_sent_cnt`, out, PCK_CNTw; `rec_sum_h2h`, out, SUMw; `rec_sum_h2t`, out, SUMw; `rec_sum_dist`, out, DSTw+PCK_CNTw; `rec_min_h2h`, out, CLK_CNTw; `rec_max_h2h`, out, CLK_CNTw.
- `dump_busy`, out, 1: dump in progress.
- `dump_done`, out, 1: one-cycle pulse after the last record is accepted.

## Operation
- Per class `c`, store `rcv_cnt`, `sent_cnt`, `sum_h2h`, `sum_h2t`, `sum_dist`, `min_h2h`, `max_h2h`.
- On `update`, class `pck_class` updates as follows:
  - `rcv_cnt` increments by 1.
  - Each sum adds its input, zero-extended.
  - `min_h2h` and `max_h2h` compare against `time_stamp_h2h` and update.
- On `sent_done`, `sent_cnt[sent_class]` increments by 1.
- Class index ≥ C: ignored, no update.
- All counters and sums saturate at all-ones; they never wrap.
- `update` and `sent_done` in the same cycle, same or different class: both are applied.
- Reset state: `min_h2h` = all-ones; `max_h2h` = 0; all other stats = 0.
- `clear` returns all stats to the reset state and forces the FSM to IDLE. `clear` has priority over `update`, `sent_done` and dump activity in the same cycle.
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE --`report_req`--> LOAD, with index=0.
  - LOAD: copy live stats of the class at `index` into the record registers → SEND.
  - SEND: `rec_valid`=1. On `rec_ready`: if index==C-1 → DONE, else index+1 → LOAD.
  - DONE: `dump_done`=1 for one cycle → IDLE.
- `report_req` while not IDLE is ignored.
- Statistics keep accumulating during a dump. A record is a snapshot taken in LOAD and held stable while `rec_valid && !rec_ready`.
- `dump_busy` = 1 in LOAD, SEND and DONE.

## Timing
- Stat update latency: 1 cycle. A value updated at edge N is visible to a LOAD at edge N+1.
- `update` in the LOAD cycle of the same class is not included in that snapshot.
- `report_req` at edge N gives LOAD at N+1 and `rec_valid` high from N+2.
- Each record costs at least 2 cycles (LOAD + SEND). With `rec_ready` tied high, a full dump takes 2C+1 cycles after IDLE exit, including DONE.
- Reset values of outputs: `rec_valid`, `dump_busy` and `dump_done` are 0; all `rec_*` data outputs are 0.
- Asynchronous `reset` mid-dump returns the block to IDLE with all stats at the reset state.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `STAT_MINMAX_EN`:
  - Defined: per-class `min_h2h`/`max_h2h` tracking is built.
  - Undefined: no min/max storage. `rec_min_h2h` and `rec_max_h2h` are tied to 0. Other behaviour is unchanged.

## Test plan
- Reset, no traffic, then `report_req` with `rec_ready`=1. Expect:
  - C records, class 0..C-1, all counts/sums 0.
  - `rec_min_h2h` all-ones (EN) or 0 (not EN).
  - `dump_done` exactly 2C+1 cycles after LOAD entry.
- 3 `update`s on class 1 with h2h=10,25,7, h2t=14,30,9, dist=2,3,1, then dump. Class 1 record: rcv=3, sum_h2h=42, sum_h2t=53, sum_dist=6, min=7, max=25; other classes 0.
- `update` class 0 and `sent_done` class 0 in the same cycle, repeated 5 times, then dump. Class 0 record: rcv=5, sent=5.
- Dump with `rec_ready` low for 4 cycles on record 0 while `update` pulses class 0. Expect:
  - Record data stable during the stall, showing the pre-LOAD value.
  - A later dump shows the incremented count.
- Drive `rcv_cnt` to saturation (MAX_PCK_NUM small, e.g. 3 ⇒ PCK_CNTw=2), then 5 updates. rcv=3, no wrap.
- `clear` asserted during SEND of class 1: next cycle `rec_valid`=0, `dump_busy`=0, stats zeroed. `reset` mid-dump behaves the same.
